// File: rtl/mcp_ctrl_hs_if.sv
// Memory handshake bundle between the multicycle controller and memory.
// The controller side uses the master modport; memory uses slave.
interface mcp_ctrl_hs_if;
    logic memreq;
    logic memwrite;
    logic memready;

    modport master (
        output memreq,
        output memwrite,
        input  memready
    );

    modport slave (
        input  memreq,
        input  memwrite,
        output memready
    );
endinterface

// File: rtl/mcp_ctrl_hs.sv
// Multicycle MIPS control unit with a memory request/ready handshake,
// a bounded wait timeout and an illegal-opcode trap.
// Optional feature macro: MCP_CTRL_BNE_EN (adds the bne instruction).
module mcp_ctrl_hs #(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [5:0]    op,
    input  logic [5:0]    funct,
    input  logic          zero,
    mcp_ctrl_hs_if.master mem,
    output logic          pcen,
    output logic          irwrite,
    output logic          regwrite,
    output logic          alusrca,
    output logic          iord,
    output logic          memtoreg,
    output logic          regdst,
    output logic [1:0]    alusrcb,
    output logic [1:0]    pcsrc,
    output logic [2:0]    alucontrol,
    output logic [3:0]    state,
    output logic          illegal,
    output logic          memerr
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BEQEX   = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JEX     = 4'd11
`ifdef MCP_CTRL_BNE_EN
        , S_BNEEX = 4'd12
`endif
    } state_t;

    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_RTYP = 6'b000000;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;
`ifdef MCP_CTRL_BNE_EN
    localparam logic [5:0] OP_BNE  = 6'b000101;
`endif

    localparam logic [7:0] LP_TMO_LAST = 8'(MEM_TIMEOUT - 1);

    state_t     r_state;
    state_t     w_next;
    logic [7:0] r_cnt;
    logic       r_illegal;
    logic       r_memerr;
    logic       w_memst;
    logic       w_timeout;
    logic       w_illop;
    logic       w_pcwrite;
    logic       w_memreq;
    logic       w_memwrite;
    logic [1:0] w_aluop;

    assign w_memst   = (r_state == S_FETCH) || (r_state == S_MEMRD) || (r_state == S_MEMWR);
    assign w_timeout = w_memst && !mem.memready && (r_cnt == LP_TMO_LAST);

    // Next-state selection; a memory timeout always falls back to FETCH
    always_comb begin
        w_next  = r_state;
        w_illop = 1'b0;
        case (r_state)
            S_FETCH: begin
                if (mem.memready) w_next = S_DECODE;
                else              w_next = S_FETCH;
            end
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_RTYP:      w_next = S_EXECUTE;
                    OP_BEQ:       w_next = S_BEQEX;
                    OP_ADDI:      w_next = S_ADDIEX;
                    OP_J:         w_next = S_JEX;
`ifdef MCP_CTRL_BNE_EN
                    OP_BNE:       w_next = S_BNEEX;
`endif
                    default: begin
                        w_next  = S_FETCH;
                        w_illop = 1'b1;
                    end
                endcase
            end
            S_MEMADR:  w_next = (op == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD: begin
                if (mem.memready)  w_next = S_MEMWB;
                else if (w_timeout) w_next = S_FETCH;
            end
            S_MEMWR: begin
                if (mem.memready || w_timeout) w_next = S_FETCH;
            end
            S_EXECUTE: w_next = S_ALUWB;
            S_ADDIEX:  w_next = S_ADDIWB;
            default:   w_next = S_FETCH;
        endcase
    end

    // State register, wait counter and registered error pulses.
    // A FETCH timeout keeps the state unchanged, so the counter is cleared
    // explicitly on timeout as well as on a state change.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_FETCH;
            r_cnt     <= '0;
            r_illegal <= 1'b0;
            r_memerr  <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_illegal <= w_illop;
            r_memerr  <= w_timeout;
            if ((w_next != r_state) || w_timeout)
                r_cnt <= '0;
            else if (w_memst && !mem.memready)
                r_cnt <= r_cnt + 8'd1;
        end
    end

    // Decoded datapath controls, all held low while reset is asserted
    always_comb begin
        w_memreq   = 1'b0;
        w_memwrite = 1'b0;
        w_pcwrite  = 1'b0;
        w_aluop    = 2'b00;
        pcen       = 1'b0;
        irwrite    = 1'b0;
        regwrite   = 1'b0;
        alusrca    = 1'b0;
        iord       = 1'b0;
        memtoreg   = 1'b0;
        regdst     = 1'b0;
        alusrcb    = 2'b00;
        pcsrc      = 2'b00;
        alucontrol = 3'b000;
        if (reset) begin
            case (r_state)
                S_FETCH: begin
                    w_memreq  = 1'b1;
                    alusrcb   = 2'b01;
                    irwrite   = mem.memready;
                    w_pcwrite = mem.memready;
                end
                S_DECODE:  alusrcb = 2'b11;
                S_MEMADR, S_ADDIEX: begin
                    alusrca = 1'b1;
                    alusrcb = 2'b10;
                end
                S_MEMRD: begin
                    w_memreq = 1'b1;
                    iord     = 1'b1;
                end
                S_MEMWR: begin
                    w_memreq   = 1'b1;
                    iord       = 1'b1;
                    w_memwrite = 1'b1;
                end
                S_MEMWB: begin
                    memtoreg = 1'b1;
                    regwrite = 1'b1;
                end
                S_EXECUTE: begin
                    alusrca = 1'b1;
                    w_aluop = 2'b10;
                end
                S_ALUWB: begin
                    regdst   = 1'b1;
                    regwrite = 1'b1;
                end
                S_ADDIWB:  regwrite = 1'b1;
                S_BEQEX: begin
                    alusrca = 1'b1;
                    w_aluop = 2'b01;
                    pcsrc   = 2'b01;
                end
`ifdef MCP_CTRL_BNE_EN
                S_BNEEX: begin
                    alusrca = 1'b1;
                    w_aluop = 2'b01;
                    pcsrc   = 2'b01;
                end
`endif
                S_JEX: begin
                    pcsrc     = 2'b10;
                    w_pcwrite = 1'b1;
                end
                default: ;
            endcase

            pcen = w_pcwrite || ((r_state == S_BEQEX) && zero);
`ifdef MCP_CTRL_BNE_EN
            pcen = pcen || ((r_state == S_BNEEX) && !zero);
`endif

            case (w_aluop)
                2'b01:   alucontrol = 3'b110;
                2'b10: begin
                    case (funct)
                        6'b100000: alucontrol = 3'b010;
                        6'b100010: alucontrol = 3'b110;
                        6'b100100: alucontrol = 3'b000;
                        6'b100101: alucontrol = 3'b001;
                        6'b101010: alucontrol = 3'b111;
                        default:   alucontrol = 3'b010;
                    endcase
                end
                default: alucontrol = 3'b010;
            endcase
        end
    end

    assign mem.memreq   = w_memreq;
    assign mem.memwrite = w_memwrite;
    assign state        = r_state;
    assign illegal      = r_illegal;
    assign memerr       = r_memerr;

endmodule

// File: tb/tb_mcp_ctrl_hs.sv
// Scoreboard bench for mcp_ctrl_hs: the stimulus pushes the expected
// control vector for every driven cycle; a monitor pops and compares it
// on the falling edge. Honours MCP_CTRL_BNE_EN if defined for the build.
module tb_mcp_ctrl_hs;

    localparam int unsigned TMO = 4;

    localparam logic [3:0] SF   = 4'd0;
    localparam logic [3:0] SD   = 4'd1;
    localparam logic [3:0] SMA  = 4'd2;
    localparam logic [3:0] SMR  = 4'd3;
    localparam logic [3:0] SMB  = 4'd4;
    localparam logic [3:0] SMW  = 4'd5;
    localparam logic [3:0] SEX  = 4'd6;
    localparam logic [3:0] SAW  = 4'd7;
    localparam logic [3:0] SBQ  = 4'd8;
    localparam logic [3:0] SAI  = 4'd9;
    localparam logic [3:0] SAIW = 4'd10;
    localparam logic [3:0] SJ   = 4'd11;
    localparam logic [3:0] SBN  = 4'd12;

`ifdef MCP_CTRL_BNE_EN
    localparam logic BNE_ILL = 1'b0;
`else
    localparam logic BNE_ILL = 1'b1;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       zero;
    logic [5:0] op;
    logic [5:0] funct;
    logic       pcen, irwrite, regwrite, alusrca, iord, memtoreg, regdst;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] alucontrol;
    logic [3:0] state;
    logic       illegal, memerr;

    mcp_ctrl_hs_if mem_if ();

    mcp_ctrl_hs #(.MEM_TIMEOUT(TMO)) dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct      (funct),
        .zero       (zero),
        .mem        (mem_if),
        .pcen       (pcen),
        .irwrite    (irwrite),
        .regwrite   (regwrite),
        .alusrca    (alusrca),
        .iord       (iord),
        .memtoreg   (memtoreg),
        .regdst     (regdst),
        .alusrcb    (alusrcb),
        .pcsrc      (pcsrc),
        .alucontrol (alucontrol),
        .state      (state),
        .illegal    (illegal),
        .memerr     (memerr)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] st;
        logic       memreq;
        logic       memwrite;
        logic       pcen;
        logic       irwrite;
        logic       regwrite;
        logic       alusrca;
        logic       iord;
        logic       memtoreg;
        logic       regdst;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic [2:0] aluc;
        logic       ill;
        logic       err;
    } vec_t;

    vec_t  exp_q[$];
    string name_q[$];
    int    checks   = 0;
    int    failures = 0;
    vec_t  mon_e;
    vec_t  mon_a;
    string mon_n;

    // Hand-written table of the expected controls per state
    function automatic vec_t exp_vec(input logic [3:0] st, input logic mr, input logic z,
                                     input logic [5:0] fn, input logic in_rst,
                                     input logic ill, input logic err);
        vec_t v;
        v     = '0;
        v.st  = st;
        v.ill = ill;
        v.err = err;
        if (in_rst) return v;
        v.aluc = 3'b010;
        case (st)
            SF:  begin v.memreq = 1'b1; v.alusrcb = 2'b01; v.irwrite = mr; v.pcen = mr; end
            SD:  v.alusrcb = 2'b11;
            SMA, SAI: begin v.alusrca = 1'b1; v.alusrcb = 2'b10; end
            SMR: begin v.memreq = 1'b1; v.iord = 1'b1; end
            SMW: begin v.memreq = 1'b1; v.iord = 1'b1; v.memwrite = 1'b1; end
            SMB: begin v.memtoreg = 1'b1; v.regwrite = 1'b1; end
            SEX: begin
                v.alusrca = 1'b1;
                case (fn)
                    6'b100010: v.aluc = 3'b110;
                    6'b100100: v.aluc = 3'b000;
                    6'b100101: v.aluc = 3'b001;
                    6'b101010: v.aluc = 3'b111;
                    default:   v.aluc = 3'b010;
                endcase
            end
            SAW:  begin v.regdst = 1'b1; v.regwrite = 1'b1; end
            SAIW: v.regwrite = 1'b1;
            SBQ:  begin v.alusrca = 1'b1; v.pcsrc = 2'b01; v.aluc = 3'b110; v.pcen = z; end
            SBN:  begin v.alusrca = 1'b1; v.pcsrc = 2'b01; v.aluc = 3'b110; v.pcen = !z; end
            SJ:   begin v.pcsrc = 2'b10; v.pcen = 1'b1; end
            default: ;
        endcase
        return v;
    endfunction

    // One clock cycle: drive inputs, queue the expectation, advance
    task automatic cyc(input string nm, input logic mr, input logic z,
                       input logic [3:0] st, input logic ill, input logic err);
        mem_if.memready = mr;
        zero            = z;
        exp_q.push_back(exp_vec(st, mr, z, funct, 1'b0, ill, err));
        name_q.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    task automatic rst_chk(input string nm);
        exp_q.push_back(exp_vec(SF, 1'b0, 1'b0, funct, 1'b1, 1'b0, 1'b0));
        name_q.push_back(nm);
    endtask

    // Monitor: compare the DUT against the oldest queued expectation
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e          = exp_q.pop_front();
            mon_n          = name_q.pop_front();
            mon_a.st       = state;
            mon_a.memreq   = mem_if.memreq;
            mon_a.memwrite = mem_if.memwrite;
            mon_a.pcen     = pcen;
            mon_a.irwrite  = irwrite;
            mon_a.regwrite = regwrite;
            mon_a.alusrca  = alusrca;
            mon_a.iord     = iord;
            mon_a.memtoreg = memtoreg;
            mon_a.regdst   = regdst;
            mon_a.alusrcb  = alusrcb;
            mon_a.pcsrc    = pcsrc;
            mon_a.aluc     = alucontrol;
            mon_a.ill      = illegal;
            mon_a.err      = memerr;
            checks++;
            if (mon_a !== mon_e) begin
                failures++;
                $display("FAIL %s actual=%h expected=%h (st,memreq,memwrite,pcen,irwrite,regwrite,alusrca,iord,memtoreg,regdst,alusrcb,pcsrc,aluc,ill,err)",
                         mon_n, mon_a, mon_e);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1);
    end

    logic [5:0] fn_tab [5];

    initial begin
        fn_tab[0] = 6'b101010;
        fn_tab[1] = 6'b100010;
        fn_tab[2] = 6'b100100;
        fn_tab[3] = 6'b100101;
        fn_tab[4] = 6'b111000;

        reset           = 1'b0;
        mem_if.memready = 1'b0;
        zero            = 1'b0;
        op              = 6'b000000;
        funct           = 6'b000000;
        repeat (2) @(posedge clk);
        #1;
        rst_chk("reset_state");
        @(posedge clk);
        #1;
        reset = 1'b1;

        // lw, zero wait
        op = 6'b100011;
        cyc("lw_fetch",  1'b1, 1'b0, SF,  1'b0, 1'b0);
        cyc("lw_decode", 1'b1, 1'b0, SD,  1'b0, 1'b0);
        cyc("lw_memadr", 1'b1, 1'b0, SMA, 1'b0, 1'b0);
        cyc("lw_memrd",  1'b1, 1'b0, SMR, 1'b0, 1'b0);
        cyc("lw_memwb",  1'b1, 1'b0, SMB, 1'b0, 1'b0);

        // sw, three wait cycles, ack lands exactly on the timeout cycle
        op = 6'b101011;
        cyc("sw_fetch",  1'b1, 1'b0, SF,  1'b0, 1'b0);
        cyc("sw_decode", 1'b1, 1'b0, SD,  1'b0, 1'b0);
        cyc("sw_memadr", 1'b1, 1'b0, SMA, 1'b0, 1'b0);
        cyc("sw_wait0",  1'b0, 1'b0, SMW, 1'b0, 1'b0);
        cyc("sw_wait1",  1'b0, 1'b0, SMW, 1'b0, 1'b0);
        cyc("sw_wait2",  1'b0, 1'b0, SMW, 1'b0, 1'b0);
        cyc("sw_ack",    1'b1, 1'b0, SMW, 1'b0, 1'b0);

        // R-type over several funct codes
        op = 6'b000000;
        for (int i = 0; i < 5; i++) begin
            funct = fn_tab[i];
            cyc("r_fetch",   1'b1, 1'b0, SF,  1'b0, 1'b0);
            cyc("r_decode",  1'b1, 1'b0, SD,  1'b0, 1'b0);
            cyc("r_execute", 1'b1, 1'b0, SEX, 1'b0, 1'b0);
            cyc("r_aluwb",   1'b1, 1'b0, SAW, 1'b0, 1'b0);
        end

        // addi
        op = 6'b001000;
        cyc("addi_fetch", 1'b1, 1'b0, SF,   1'b0, 1'b0);
        cyc("addi_dec",   1'b1, 1'b0, SD,   1'b0, 1'b0);
        cyc("addi_ex",    1'b1, 1'b0, SAI,  1'b0, 1'b0);
        cyc("addi_wb",    1'b1, 1'b0, SAIW, 1'b0, 1'b0);

        // beq taken then not taken; j
        op = 6'b000100;
        cyc("beq1_fetch", 1'b1, 1'b0, SF,  1'b0, 1'b0);
        cyc("beq1_dec",   1'b1, 1'b0, SD,  1'b0, 1'b0);
        cyc("beq_taken",  1'b1, 1'b1, SBQ, 1'b0, 1'b0);
        cyc("beq0_fetch", 1'b1, 1'b0, SF,  1'b0, 1'b0);
        cyc("beq0_dec",   1'b1, 1'b0, SD,  1'b0, 1'b0);
        cyc("beq_not",    1'b1, 1'b0, SBQ, 1'b0, 1'b0);
        op = 6'b000010;
        cyc("j_fetch",    1'b1, 1'b0, SF,  1'b0, 1'b0);
        cyc("j_dec",      1'b1, 1'b0, SD,  1'b0, 1'b0);
        cyc("j_ex",       1'b1, 1'b0, SJ,  1'b0, 1'b0);

        // illegal opcode, then bne
        op = 6'b111111;
        cyc("ill_fetch",  1'b1, 1'b0, SF, 1'b0, 1'b0);
        cyc("ill_dec",    1'b1, 1'b0, SD, 1'b0, 1'b0);
        op = 6'b000101;
        cyc("ill_pulse",  1'b1, 1'b0, SF, 1'b1, 1'b0);
        cyc("bne_dec",    1'b1, 1'b0, SD, 1'b0, 1'b0);
`ifdef MCP_CTRL_BNE_EN
        cyc("bne_taken",  1'b1, 1'b0, SBN, 1'b0, 1'b0);
`endif

        // fetch timeout: four cycles without ready, then a re-fetch
        op = 6'b001000;
        cyc("tmo_f0",     1'b0, 1'b0, SF,   BNE_ILL, 1'b0);
        cyc("tmo_f1",     1'b0, 1'b0, SF,   1'b0, 1'b0);
        cyc("tmo_f2",     1'b0, 1'b0, SF,   1'b0, 1'b0);
        cyc("tmo_f3",     1'b0, 1'b0, SF,   1'b0, 1'b0);
        cyc("tmo_refetch",1'b1, 1'b0, SF,   1'b0, 1'b1);
        cyc("tmo_dec",    1'b1, 1'b0, SD,   1'b0, 1'b0);
        cyc("tmo_addiex", 1'b1, 1'b0, SAI,  1'b0, 1'b0);
        cyc("tmo_addiwb", 1'b1, 1'b0, SAIW, 1'b0, 1'b0);

        // MEMRD timeout aborts without writeback
        op = 6'b100011;
        cyc("rdt_fetch",  1'b1, 1'b0, SF,  1'b0, 1'b0);
        cyc("rdt_dec",    1'b1, 1'b0, SD,  1'b0, 1'b0);
        cyc("rdt_memadr", 1'b1, 1'b0, SMA, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++)
            cyc("rdt_wait", 1'b0, 1'b0, SMR, 1'b0, 1'b0);
        cyc("rdt_refetch",1'b1, 1'b0, SF,  1'b0, 1'b1);
        cyc("rdt_dec2",   1'b1, 1'b0, SD,  1'b0, 1'b0);

        // asynchronous reset while waiting in MEMRD
        cyc("arst_memadr",1'b1, 1'b0, SMA, 1'b0, 1'b0);
        cyc("arst_memrd", 1'b0, 1'b0, SMR, 1'b0, 1'b0);
        reset = 1'b0;
        #1;
        rst_chk("arst_in_memrd");
        @(posedge clk);
        #1;
        reset = 1'b1;
        cyc("arst_fetch", 1'b1, 1'b0, SF,  1'b0, 1'b0);
        cyc("arst_dec",   1'b1, 1'b0, SD,  1'b0, 1'b0);

        for (int i = 0; i < 20 && exp_q.size() > 0; i++)
            @(posedge clk);
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain actual=%0d pending required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mcp_ctrl_hs.md
# mcp_ctrl_hs

Multicycle MIPS control unit with a memory ready/request handshake, bounded wait timeout and illegal-opcode trap. It sits between the instruction register and the multicycle datapath. It drives every datapath enable and mux select, and stalls in fetch and data-memory states until memory acknowledges. It extends the base multicycle controller with variable-latency memory, `addi`, `j`, error reporting, and an optional `bne`.

## Interface
- MEM_TIMEOUT, 15: maximum consecutive cycles spent in one memory state with memready=0 (range 1..255).
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- op  in  6  instr[31:26].
- funct  in  6  instr[5:0].
- zero  in  1  ALU zero flag.
- memready  in  1  memory acknowledge; completes the current access.
- memreq  out  1  memory access request.
- pcen  out  1  PC register enable.
- memwrite  out  1  memory write strobe.
- irwrite  out  1  IR load.
- regwrite  out  1  register file write.
- alusrca, iord, memtoreg, regdst  out  1 each  datapath selects.
- alusrcb, pcsrc  out  2 each  datapath selects.
- alucontrol  out  3  ALU operation.
- state  out  4  current state, for debug.
- illegal  out  1  one-cycle pulse on an undecodable opcode.
- memerr  out  1  one-cycle pulse on memory timeout.

## Operation
State encodings:
- FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5
- EXECUTE 6, ALUWB 7, BEQEX 8, ADDIEX 9, ADDIWB 10, JEX 11, BNEEX 12

Opcodes: lw 100011, sw 101011, R-type 000000, beq 000100, addi 001000, j 000010, bne 000101.

Per-state outputs. Any output not listed is 0.
- FETCH: memreq=1, iord=0, alusrca=0, alusrcb=01, aluop=00, pcsrc=00. irwrite and pcwrite are asserted only in the cycle where memready=1.
- DECODE: alusrcb=11, aluop=00.
- MEMADR and ADDIEX: alusrca=1, alusrcb=10, aluop=00.
- MEMRD: memreq=1, iord=1.
- MEMWR: memreq=1, iord=1, memwrite=1.
- MEMWB: memtoreg=1, regwrite=1.
- EXECUTE: alusrca=1, aluop=10.
- ALUWB: regdst=1, regwrite=1.
- ADDIWB: regwrite=1.
- BEQEX and BNEEX: alusrca=1, aluop=01, pcsrc=01.
- JEX: pcsrc=10, pcwrite=1.

Branch and PC enable:
- pcen = pcwrite | (BEQEX & zero) | (BNEEX & ~zero).

ALU decode:
- aluop 00 gives alucontrol 010; aluop 01 gives 110.
- aluop 10 decodes funct: 100000→010, 100010→110, 100100→000, 100101→001, 101010→111, any other funct→010.

Transitions:
- FETCH→DECODE on memready.
- DECODE dispatches on op:
  - lw or sw → MEMADR
  - R-type → EXECUTE
  - beq → BEQEX
  - addi → ADDIEX
  - j → JEX
  - bne → BNEEX (only when the macro is enabled)
  - any other op → FETCH, with illegal=1 on the next cycle.
- MEMADR → MEMRD for lw, → MEMWR for sw.
- MEMRD → MEMWB on memready.
- MEMWR → FETCH on memready.
- EXECUTE→ALUWB and ADDIEX→ADDIWB.
- MEMWB, ALUWB, ADDIWB, BEQEX, BNEEX and JEX each return to FETCH.

Wait counter:
- 8 bits. Increments each cycle a memory state (FETCH, MEMRD, MEMWR) sees memready=0, and clears on any state change.
- Timeout condition: memready=0 while the counter equals MEM_TIMEOUT-1.
- On timeout the next state is FETCH, memerr=1 on the next cycle, and no irwrite, pcwrite or regwrite is issued for the aborted access.
- A timeout in FETCH re-fetches the same PC.

## Timing
- Reset (reset=0): state=FETCH, counter=0, illegal=0, memerr=0. All decoded outputs, including memreq, are forced to 0 while reset is low.
- Reset is asynchronous: assertion takes effect immediately, mid-instruction, and aborts any pending access with no memerr.
- Decoded outputs are combinational from state, memready and zero. illegal and memerr are registered.
- Zero-wait latency, in cycles:
  - lw 5
  - sw 4
  - R-type 4
  - addi 4
  - beq 3
  - bne 3
  - j 3
- Each memory state adds one cycle per cycle memready is low.
- memready is ignored in non-memory states.
- memreq stays high until memready or timeout. Memory must not deassert memready mid-access.
- memready=1 in the timeout cycle counts as success; the timeout does not fire.
- MEM_TIMEOUT=1: timeout whenever memready=0 in the first cycle of a memory state.

## Configuration
- MCP_CTRL_BNE_EN defined: opcode 000101 decodes to BNEEX, which branches when zero=0.
- MCP_CTRL_BNE_EN undefined: BNEEX is absent, and 000101 is illegal (DECODE→FETCH with an illegal pulse).
- State encoding 12 is unused when the macro is undefined.

## Test plan
- lw with memready tied 1: state sequence 0,1,2,3,4,0. irwrite and pcen high in cycle 0. regwrite=1 and memtoreg=1 in state 4.
- sw with memready low for 3 cycles in MEMWR: memwrite and memreq held 4 cycles, then FETCH. No memerr.
- R-type funct 101010 then 100010: alucontrol=111 then 110 in EXECUTE. regdst=1 and regwrite=1 in ALUWB.
- beq with zero=1 then zero=0: pcen=1 then 0 in BEQEX, pcsrc=01 in both. j: pcen=1, pcsrc=10.
- MEM_TIMEOUT=4, memready held 0 in FETCH: after 4 cycles state=FETCH again and memerr pulses once. No irwrite or pcen.
- op=111111: illegal pulses one cycle after DECODE. op=000101 is illegal without MCP_CTRL_BNE_EN. With the macro, BNEEX gives pcen=1 for zero=0. Reset asserted in MEMRD returns to FETCH immediately with memreq=0.
